// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - round-robin scheduler for two requesters sharing one iterative shift-add multiplier
// Captures the winner's operands, sequences load/run, returns the product with a done pulse and a watchdog flag.
module mult_sched #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [SIZE-1:0]   a0,
  input  logic [SIZE-1:0]   b0,
  input  logic              req1,
  input  logic [SIZE-1:0]   a1,
  input  logic [SIZE-1:0]   b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [2*SIZE-1:0] res,
  output logic              err,
  output logic              busy,
  output logic [SIZE-1:0]   mul_a,
  output logic [SIZE-1:0]   mul_b,
  output logic              mul_start,
  input  logic              mul_fin,
  input  logic [SIZE-1:0]   mul_hm,
  input  logic [SIZE-1:0]   mul_lm
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int RCW = $clog2(SIZE + 5);
  // Last RUN count before the watchdog gives up: RUN lasts at most SIZE+4 cycles.
  localparam logic [RCW-1:0] RC_LAST = RCW'(SIZE + 3);

  state_t         state;
  logic           lp;
  logic           owner;
  logic [RCW-1:0] rc;
  logic           pick1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  always_comb begin
    pick1 = req1 && (!req0 || !lp);
  end

  assign busy      = (state != IDLE);
  assign mul_start = (state == RUN) && !mul_fin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lp    <= 1'b1;
      owner <= 1'b0;
      rc    <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      res   <= '0;
      err   <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= pick1;
            mul_a <= pick1 ? a1 : a0;
            mul_b <= pick1 ? b1 : b0;
            gnt0  <= !pick1;
            gnt1  <= pick1;
            state <= LOAD;
          end
        end
        LOAD: begin
          rc    <= '0;
          state <= RUN;
        end
        RUN: begin
          rc <= rc + RCW'(1);
          if (mul_fin) begin
            res   <= {mul_hm, mul_lm};
            err   <= 1'b0;
            done0 <= !owner;
            done1 <= owner;
            state <= DONE;
          end else if (rc == RC_LAST) begin
            res   <= '0;
            err   <= 1'b1;
            done0 <= !owner;
            done1 <= owner;
            state <= DONE;
          end
        end
        DONE: begin
          lp    <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - self-checking bench for mult_sched with a behavioural iterative multiplier
module tb_mult_sched;
  localparam int SIZE = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, err, busy, mul_start, mul_fin;
  logic [15:0] res;
  logic [7:0]  mul_a, mul_b, mul_hm, mul_lm;

  logic        stub = 1'b0;
  logic        m_fin;
  logic [15:0] m_prod;
  int          m_cnt;

  int errors = 0;
  int checks = 0;
  int last_owner = 1;

  mult_sched #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .err(err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_fin(mul_fin), .mul_hm(mul_hm), .mul_lm(mul_lm)
  );

  always #5 clk = ~clk;

  // Multiplier: loads while start=0, finishes after SIZE iterate edges; result halves are garbage until fin.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_fin <= 1'b0; m_cnt <= 0; m_prod <= '0;
    end else if (!mul_start) begin
      m_fin <= 1'b0; m_cnt <= 0; m_prod <= 16'(mul_a) * 16'(mul_b);
    end else if (!m_fin) begin
      m_cnt <= m_cnt + 1;
      m_fin <= (m_cnt + 1 == SIZE);
    end
  end
  assign mul_fin = stub ? 1'b0 : m_fin;
  assign {mul_hm, mul_lm} = m_fin ? m_prod : ~m_prod;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("gnt_exclusive", int'(gnt0 & gnt1), 0);
      check("done_exclusive", int'(done0 & done1), 0);
    end
  end

  function automatic bit sig(input int w);
    case (w)
      0: return gnt0;
      1: return gnt1;
      2: return done0;
      default: return done1;
    endcase
  endfunction

  task automatic wait_pulse(input int w, input int budget, input string name, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!sig(w) && n < budget);
    if (!sig(w)) begin
      checks++; errors++;
      $display("FAIL %s: timeout after %0d cycles, expected pulse", name, n);
      n = -1;
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_gnt"}, int'({gnt0, gnt1}), 0);
    check({name, "_done"}, int'({done0, done1}), 0);
    check({name, "_res"}, int'(res), 0);
    check({name, "_err"}, int'(err), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_mul"}, int'({mul_a, mul_b, mul_start}), 0);
  endtask

  // One isolated request; optionally disturbs the operands right after the grant.
  task automatic single_op(input int who, input int a, input int b, input int exp_res,
                           input int exp_err, input int exp_lat, input bit disturb, input string name);
    int n, lat;
    if (who == 0) begin a0 = 8'(a); b0 = 8'(b); req0 = 1'b1; end
    else          begin a1 = 8'(a); b1 = 8'(b); req1 = 1'b1; end
    wait_pulse(who, 20, {name, "_gnt"}, n);
    if (disturb) begin a0 = 8'd200; b0 = 8'd3; end
    wait_pulse(who + 2, 30, {name, "_done"}, lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_res"}, int'(res), exp_res);
    check({name, "_err"}, int'(err), exp_err);
    req0 = 1'b0; req1 = 1'b0;
    last_owner = who;
    @(negedge clk);
  endtask

  typedef struct { int who; int a; int b; int res; } vec_t;
  vec_t tbl[6];

  initial begin
    int n, ownr, exp_owner, ndone;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, ownr, exp_owner, ndone, ra, rb, w;
    tbl[0] = '{0, 13, 11, 143};
    tbl[1] = '{1, 255, 255, 65025};
    tbl[2] = '{0, 0, 77, 0};
    tbl[3] = '{1, 1, 255, 255};
    tbl[4] = '{0, 128, 2, 256};
    tbl[5] = '{1, 16, 16, 256};

    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic product and latency from the table.
    foreach (tbl[i])
      single_op(tbl[i].who, tbl[i].a, tbl[i].b, tbl[i].res, 0, 10, 1'b0, $sformatf("tbl%0d", i));

    // Operands changed after the grant must not affect the result.
    single_op(0, 13, 11, 143, 0, 10, 1'b1, "capture");

    // Random isolated operations checked against plain multiplication.
    for (int i = 0; i < 6; i++) begin
      w = int'($urandom_range(0, 1)); ra = int'($urandom_range(0, 255)); rb = int'($urandom_range(0, 255));
      single_op(w, ra, rb, ra * rb, 0, 10, 1'b0, $sformatf("rand%0d", i));
    end

    // Simultaneous requests after reset: requester 0 wins first.
    reset = 1'b1; @(negedge clk); reset = 1'b0; last_owner = 1;
    a0 = 8'd255; b0 = 8'd255; a1 = 8'd7; b1 = 8'd9; req0 = 1'b1; req1 = 1'b1;
    wait_pulse(0, 20, "tie_gnt0", n);
    check("tie_no_gnt1", int'(gnt1), 0);
    wait_pulse(2, 30, "tie_done0", n);
    check("tie_res0", int'(res), 65025);
    req0 = 1'b0;
    wait_pulse(1, 20, "tie_gnt1", n);
    wait_pulse(3, 30, "tie_done1", n);
    check("tie_res1", int'(res), 63);
    req1 = 1'b0; last_owner = 1;
    @(negedge clk);

    // Both held for four operations: strict alternation.
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    exp_owner = 1 - last_owner;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(done0 || done1) && n < 30);
      if (!(done0 || done1)) begin
        checks++; errors++;
        $display("FAIL alt%0d: timeout waiting for done", k);
      end else begin
        ownr = done1 ? 1 : 0;
        check($sformatf("alt%0d_owner", k), ownr, exp_owner);
        check($sformatf("alt%0d_res", k), int'(res), ownr ? int'(a1) * int'(b1) : int'(a0) * int'(b0));
        if (ownr == 1) begin a1 = 8'($urandom); b1 = 8'($urandom); end
        else           begin a0 = 8'($urandom); b0 = 8'($urandom); end
        exp_owner = 1 - ownr;
        last_owner = ownr;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    check("alt_idle_busy", int'(busy), 0);

    // Reset in RUN cycle 4 aborts the operation.
    a0 = 8'd50; b0 = 8'd60; req0 = 1'b1;
    wait_pulse(0, 20, "abort_gnt", n);
    repeat (4) @(negedge clk);
    check("abort_running", int'({busy, mul_start}), 3);
    reset = 1'b1;
    #1;
    check_zero_outputs("abort");
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0; last_owner = 1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 || done1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    single_op(1, 100, 100, 10000, 0, 10, 1'b0, "after_abort");

    // Dead multiplier: watchdog ends RUN after SIZE+4 cycles.
    stub = 1'b1;
    single_op(0, 5, 6, 0, 1, 13, 1'b0, "wdog");
    check("wdog_idle", int'(busy), 0);
    stub = 1'b0;
    single_op(1, 3, 4, 12, 0, 10, 1'b0, "wdog_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
